// File: rtl/video_pkg.sv
// Shared video definitions: colour constants, 720p timing defaults and the
// read-controller state encoding.
package video_pkg;

  localparam int CNT_W = 11;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  localparam int H_DISP_720P = 1280;
  localparam int H_FP_720P   = 110;
  localparam int H_SYNC_720P = 40;
  localparam int H_BP_720P   = 220;
  localparam int V_DISP_720P = 720;
  localparam int V_FP_720P   = 5;
  localparam int V_SYNC_720P = 5;
  localparam int V_BP_720P   = 20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } rd_state_e;

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster h/v counters with active-area and raw sync decode; all decodes are
// forced low while en_i is low so an idle controller shows a quiet raster.
module vid_timing_cnt
  import video_pkg::*;
#(
  parameter int H_DISP = H_DISP_720P,
  parameter int H_FP   = H_FP_720P,
  parameter int H_SYNC = H_SYNC_720P,
  parameter int H_BP   = H_BP_720P,
  parameter int V_DISP = V_DISP_720P,
  parameter int V_FP   = V_FP_720P,
  parameter int V_SYNC = V_SYNC_720P,
  parameter int V_BP   = V_BP_720P
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             act_o,
  output logic             hs_raw_o,
  output logic             vs_raw_o,
  output logic             h_wrap_o,
  output logic             v_wrap_o
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_width_chk
    $error("vid_timing_cnt: timing totals do not fit the counter width");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP_L = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_DISP_L = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISP + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign act_o    = en_i && (h_cnt_q < H_DISP_L) && (v_cnt_q < V_DISP_L);
  assign hs_raw_o = en_i && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_raw_o = en_i && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign h_wrap_o = en_i && (h_cnt_q == H_LAST);
  assign v_wrap_o = h_wrap_o && (v_cnt_q == V_LAST);

endmodule

// File: rtl/img_scale_rd_ctrl.sv
// Display read scheduler: raster timing plus SCALE x SCALE pixel replication of
// an IMG_W x IMG_H image, using sub-counters rather than multiply/divide.
//   state        | meaning
//   ST_IDLE      | raster parked at (0,0), outputs quiet, waiting for enable
//   ST_RUN       | frames generated back to back
//   ST_STOP_PEND | enable dropped; finish current frame, then IDLE
module img_scale_rd_ctrl
  import video_pkg::*;
#(
  parameter int          H_DISP     = H_DISP_720P,
  parameter int          H_FP       = H_FP_720P,
  parameter int          H_SYNC     = H_SYNC_720P,
  parameter int          H_BP       = H_BP_720P,
  parameter int          V_DISP     = V_DISP_720P,
  parameter int          V_FP       = V_FP_720P,
  parameter int          V_SYNC     = V_SYNC_720P,
  parameter int          V_BP       = V_BP_720P,
  parameter int          IMG_W      = 96,
  parameter int          IMG_H      = 96,
  parameter int          SCALE      = 10,
  parameter int          ADDR_W     = 14,
  parameter logic [23:0] BORDER_RGB = BLUE
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic [23:0]       pixel_data,
  output logic              frame_start,
  output logic              busy
);

  localparam int SXW = $clog2(IMG_W + 1);
  localparam int SYW = $clog2(IMG_H + 1);
  localparam int SSW = $clog2(SCALE + 1);

  if (SCALE < 1 || IMG_W * IMG_H > (1 << ADDR_W)) begin : g_param_chk
    $error("img_scale_rd_ctrl: SCALE or ADDR_W out of range");
  end

  localparam logic [SXW-1:0]    IMG_W_L    = SXW'(IMG_W);
  localparam logic [SYW-1:0]    IMG_H_L    = SYW'(IMG_H);
  localparam logic [SSW-1:0]    SCALE_LAST = SSW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
  localparam logic [CNT_W-1:0]  V_DISP_L   = CNT_W'(V_DISP);

  rd_state_e state_q, state_d;
  logic running;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic act, hs_raw, vs_raw, h_wrap, v_wrap;

  assign running = (state_q != ST_IDLE);

  vid_timing_cnt #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i   (pixel_clk),
    .rst_i   (sys_rst),
    .en_i    (running),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .act_o   (act),
    .hs_raw_o(hs_raw),
    .vs_raw_o(vs_raw),
    .h_wrap_o(h_wrap),
    .v_wrap_o(v_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (enable) state_d = ST_RUN;
      ST_RUN:       if (!enable) state_d = ST_STOP_PEND;
      ST_STOP_PEND: begin
        if (enable)      state_d = ST_RUN;
        else if (v_wrap) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  logic [SSW-1:0]    sx_sub_q, sx_sub_d, sy_sub_q, sy_sub_d;
  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              sx_ok, sy_ok, in_img, fs_raw;

  assign sx_ok  = (sx_q < IMG_W_L);
  assign sy_ok  = (sy_q < IMG_H_L);
  assign in_img = act && sx_ok && sy_ok;
  assign fs_raw = running && (h_cnt == '0) && (v_cnt == '0);

  // Register values describe the pixel at the current h_cnt, so clearing on
  // the wrap makes them zero exactly when h_cnt (or the frame) restarts.
  always_comb begin
    sx_sub_d   = sx_sub_q;
    sx_d       = sx_q;
    sy_sub_d   = sy_sub_q;
    sy_d       = sy_q;
    row_base_d = row_base_q;
    if (h_wrap) begin
      sx_sub_d = '0;
      sx_d     = '0;
    end else if (act && sx_ok) begin
      if (sx_sub_q == SCALE_LAST) begin
        sx_sub_d = '0;
        sx_d     = sx_q + 1'b1;
      end else begin
        sx_sub_d = sx_sub_q + 1'b1;
      end
    end
    if (v_wrap) begin
      sy_sub_d   = '0;
      sy_d       = '0;
      row_base_d = '0;
    end else if (h_wrap && (v_cnt < V_DISP_L) && sy_ok) begin
      if (sy_sub_q == SCALE_LAST) begin
        sy_sub_d   = '0;
        sy_d       = sy_q + 1'b1;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        sy_sub_d = sy_sub_q + 1'b1;
      end
    end
  end

  logic              rd_en_q, de_q1, hs_q1, vs_q1, img_q1, fs_q1;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CNT_W-1:0]  x_q1, y_q1, x_q2, y_q2;
  logic              de_q2, hs_q2, vs_q2, img_q2, fs_q2;

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      sx_sub_q   <= '0;
      sx_q       <= '0;
      sy_sub_q   <= '0;
      sy_q       <= '0;
      row_base_q <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      de_q1      <= 1'b0;
      hs_q1      <= 1'b0;
      vs_q1      <= 1'b0;
      img_q1     <= 1'b0;
      fs_q1      <= 1'b0;
      x_q1       <= '0;
      y_q1       <= '0;
      de_q2      <= 1'b0;
      hs_q2      <= 1'b0;
      vs_q2      <= 1'b0;
      img_q2     <= 1'b0;
      fs_q2      <= 1'b0;
      x_q2       <= '0;
      y_q2       <= '0;
    end else begin
      state_q    <= state_d;
      sx_sub_q   <= sx_sub_d;
      sx_q       <= sx_d;
      sy_sub_q   <= sy_sub_d;
      sy_q       <= sy_d;
      row_base_q <= row_base_d;
      rd_en_q    <= in_img;
      if (in_img) rd_addr_q <= row_base_q + ADDR_W'(sx_q);
      de_q1      <= act;
      hs_q1      <= hs_raw;
      vs_q1      <= vs_raw;
      img_q1     <= in_img;
      fs_q1      <= fs_raw;
      x_q1       <= h_cnt;
      y_q1       <= v_cnt;
      de_q2      <= de_q1;
      hs_q2      <= hs_q1;
      vs_q2      <= vs_q1;
      img_q2     <= img_q1;
      fs_q2      <= fs_q1;
      x_q2       <= x_q1;
      y_q2       <= y_q1;
    end
  end

  // The memory's own output register supplies the data half of stage 2.
  assign pixel_data  = img_q2 ? rd_data : (de_q2 ? BORDER_RGB : 24'h0);
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign de          = de_q2;
  assign hs          = hs_q2;
  assign vs          = vs_q2;
  assign pixel_xpos  = x_q2;
  assign pixel_ypos  = y_q2;
  assign frame_start = fs_q2;
  assign busy        = running;

endmodule
